// File: rtl/eth_rx_frame_strip_if.sv
// PHY RX byte stream in, stripped frame bytes and per-frame status out.
// slave is the stripper side; master is the PHY/consumer side that drives the bytes in.
interface eth_rx_frame_strip_if;
    logic [7:0]  i_data;
    logic        i_data_vl;
    logic [7:0]  o_data;
    logic        o_data_vl;
    logic        o_sof;
    logic        o_done;
    logic [1:0]  o_err_code;
    logic [10:0] o_frame_len;
    logic [15:0] o_good_cnt;
    logic [15:0] o_bad_cnt;

    modport slave (
        input  i_data, i_data_vl,
        output o_data, o_data_vl, o_sof, o_done, o_err_code, o_frame_len,
               o_good_cnt, o_bad_cnt
    );

    modport master (
        output i_data, i_data_vl,
        input  o_data, o_data_vl, o_sof, o_done, o_err_code, o_frame_len,
               o_good_cnt, o_bad_cnt
    );
endinterface

// File: rtl/eth_rx_frame_strip.sv
// Ethernet RX front-end: strips preamble/SFD and FCS, reports per-frame status and counters.
// Define ETH_RX_FCS_CHECK_EN to build the CRC-32 checker (err=1 on FCS mismatch).
module eth_rx_frame_strip #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic                       eth_rx_clk,
    input  logic                       rst_n,
    eth_rx_frame_strip_if.slave        bus
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_DROP, S_DROP_LONG} state_t;

    localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME_LEN);
    localparam logic [1:0]  ERR_OK   = 2'd0;
    localparam logic [1:0]  ERR_FCS  = 2'd1;
    localparam logic [1:0]  ERR_RUNT = 2'd2;
    localparam logic [1:0]  ERR_LONG = 2'd3;

    state_t          state_q, state_d;
    logic [2:0]      pcnt_q, pcnt_d;
    logic [10:0]     len_q, len_d, len_inc;
    logic [3:0][7:0] pipe_q, pipe_d;
    logic [7:0]      data_q, data_d;
    logic            data_vl_q, data_vl_d;
    logic            sof_q, sof_d;
    logic            done_q, done_d;
    logic [1:0]      err_q, err_d;
    logic [10:0]     flen_q, flen_d;
    logic [15:0]     good_q, good_d;
    logic [15:0]     bad_q, bad_d;
    logic            fcs_bad;

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] bit_rev32(input logic [31:0] c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = c[31-i];
        end
        return r;
    endfunction

    always_comb begin
        crc_d = crc_q;
        if (state_q == S_PRE && bus.i_data_vl && bus.i_data == 8'hD5) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (state_q == S_DATA && bus.i_data_vl) begin
            crc_d = crc32_byte(crc_q, bus.i_data);
        end
    end

    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) crc_q <= '0;
        else        crc_q <= crc_d;
    end

    // Register is kept in reflected order; the magic residue is quoted in normal bit order.
    assign fcs_bad = (bit_rev32(crc_q) != 32'hC704DD7B);
`else
    assign fcs_bad = 1'b0;
`endif

    assign len_inc = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        len_d     = len_q;
        pipe_d    = pipe_q;
        data_d    = data_q;
        data_vl_d = 1'b0;
        sof_d     = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        flen_d    = flen_q;
        good_d    = good_q;
        bad_d     = bad_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.i_data_vl) begin
                    if (bus.i_data == 8'h55) begin
                        state_d = S_PRE;
                        pcnt_d  = 3'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_PRE: begin
                if (!bus.i_data_vl) begin
                    state_d = S_IDLE;
                end else if (bus.i_data == 8'h55) begin
                    pcnt_d = (pcnt_q == 3'd7) ? pcnt_q : pcnt_q + 3'd1;
                end else if (bus.i_data == 8'hD5) begin
                    state_d = S_DATA;
                    len_d   = '0;
                end else begin
                    state_d = S_DROP;
                end
            end
            S_DATA: begin
                if (!bus.i_data_vl) begin
                    state_d = S_IDLE;
                    pipe_d  = '0;
                    done_d  = 1'b1;
                    flen_d  = len_q;
                    err_d   = (len_q < MIN_LEN) ? ERR_RUNT : (fcs_bad ? ERR_FCS : ERR_OK);
                end else begin
                    len_d  = len_inc;
                    pipe_d = {pipe_q[2:0], bus.i_data};
                    if (len_inc > MAX_LEN) begin
                        state_d = S_DROP_LONG;
                        pipe_d  = '0;
                    end else if (len_q >= 11'd4) begin
                        // Only bytes that are at least four behind the newest can't be FCS.
                        data_vl_d = 1'b1;
                        data_d    = pipe_q[3];
                        sof_d     = (len_q == 11'd4);
                    end
                end
            end
            S_DROP: begin
                if (!bus.i_data_vl) state_d = S_IDLE;
            end
            S_DROP_LONG: begin
                if (!bus.i_data_vl) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    flen_d  = len_q;
                    err_d   = ERR_LONG;
                end else begin
                    len_d = len_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done_d) begin
            if (err_d == ERR_OK) good_d = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
            else                 bad_d  = (bad_q  == 16'hFFFF) ? bad_q  : bad_q  + 16'd1;
        end
    end

    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pcnt_q    <= '0;
            len_q     <= '0;
            pipe_q    <= '0;
            data_q    <= '0;
            data_vl_q <= 1'b0;
            sof_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            flen_q    <= '0;
            good_q    <= '0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            len_q     <= len_d;
            pipe_q    <= pipe_d;
            data_q    <= data_d;
            data_vl_q <= data_vl_d;
            sof_q     <= sof_d;
            done_q    <= done_d;
            err_q     <= err_d;
            flen_q    <= flen_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_data_vl   = data_vl_q;
    assign bus.o_sof       = sof_q;
    assign bus.o_done      = done_q;
    assign bus.o_err_code  = err_q;
    assign bus.o_frame_len = flen_q;
    assign bus.o_good_cnt  = good_q;
    assign bus.o_bad_cnt   = bad_q;
endmodule
